// File: rtl/cdb_writeback_queue_if.sv
// Result-collection and PRF-writeback bus shared by the functional units,
// the writeback queue and the register-file / wake-up consumers.
interface cdb_writeback_queue_if #(
  parameter int N_FU  = 4,
  parameter int DEPTH = 8,
  parameter int ROB_W = 5,
  parameter int PRN_W = 6
);
  logic                             flush;
  logic [N_FU-1:0]                  fu_valid;
  logic [N_FU-1:0][PRN_W-1:0]       fu_prn;
  logic [N_FU-1:0][31:0]            fu_data;
  logic [N_FU-1:0][ROB_W-1:0]       fu_rob_idx;
  logic                             fu_ready;
  logic [1:0]                       wr_en;
  logic [1:0][PRN_W-1:0]            wr_idx;
  logic [1:0][31:0]                 wr_data;
  logic [1:0][ROB_W-1:0]            cdb_rob_idx;
  logic [$clog2(DEPTH):0]           count;

  modport master (
    output flush, fu_valid, fu_prn, fu_data, fu_rob_idx,
    input  fu_ready, wr_en, wr_idx, wr_data, cdb_rob_idx, count
  );

  modport slave (
    input  flush, fu_valid, fu_prn, fu_data, fu_rob_idx,
    output fu_ready, wr_en, wr_idx, wr_data, cdb_rob_idx, count
  );
endinterface

// File: rtl/cdb_writeback_queue.sv
// Circular buffer that funnels up to N_FU completed results per cycle into the
// two PRF write ports, oldest first, and broadcasts their ROB tags.
module cdb_writeback_queue #(
  parameter int N_FU  = 4,
  parameter int DEPTH = 8,
  parameter int ROB_W = 5,
  parameter int PRF   = 64,
  parameter int PRN_W = $clog2(PRF)
) (
  input  logic                 clock,
  input  logic                 reset,
  cdb_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(N_FU + 1);

  logic [PRN_W-1:0] ent_prn  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [ROB_W-1:0] ent_rob  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic          ready;
  logic [N_FU-1:0] accept;
  logic [AW-1:0] num_acc;
  logic [PW-1:0] slot [N_FU];
  logic [1:0]    wr_en;
  logic [1:0]    num_pop;
  logic [PW-1:0] head_p1;

  // Readiness looks only at registered occupancy so it never depends on pops.
  always_comb begin
    ready   = (count <= CW'(DEPTH - N_FU));
    accept  = bus.fu_valid & {N_FU{ready & ~bus.flush}};
    num_acc = '0;
    for (int i = 0; i < N_FU; i++) begin
      slot[i] = tail + PW'(num_acc);
      if (accept[i]) num_acc = num_acc + AW'(1);
    end
    wr_en[0]   = (count != '0) && !bus.flush;
    wr_en[1]   = (count >= CW'(2)) && !bus.flush;
    num_pop    = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
    head_p1    = head + PW'(1);
    count_next = count + CW'(num_acc) - CW'(num_pop);
  end

  assign bus.fu_ready       = ready;
  assign bus.count          = count;
  assign bus.wr_en          = wr_en;
  assign bus.wr_idx[0]      = wr_en[0] ? ent_prn[head]     : '0;
  assign bus.wr_data[0]     = wr_en[0] ? ent_data[head]    : '0;
  assign bus.cdb_rob_idx[0] = wr_en[0] ? ent_rob[head]     : '0;
  assign bus.wr_idx[1]      = wr_en[1] ? ent_prn[head_p1]  : '0;
  assign bus.wr_data[1]     = wr_en[1] ? ent_data[head_p1] : '0;
  assign bus.cdb_rob_idx[1] = wr_en[1] ? ent_rob[head_p1]  : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        ent_prn[d]  <= '0;
        ent_data[d] <= '0;
        ent_rob[d]  <= '0;
      end
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (accept[i]) begin
          ent_prn[slot[i]]  <= bus.fu_prn[i];
          ent_data[slot[i]] <= bus.fu_data[i];
          ent_rob[slot[i]]  <= bus.fu_rob_idx[i];
        end
      end
      head  <= head + PW'(num_pop);
      tail  <= tail + PW'(num_acc);
      count <= count_next;
    end
  end
endmodule

// File: tb/tb_cdb_writeback_queue.sv
// Directed and randomized bench for cdb_writeback_queue against an in-order
// queue model of the results that have been accepted but not yet written.
module tb_cdb_writeback_queue;
  localparam int N_FU  = 4;
  localparam int DEPTH = 8;
  localparam int ROB_W = 5;
  localparam int PRF   = 64;
  localparam int PRN_W = 6;

  typedef struct packed {
    logic [PRN_W-1:0] prn;
    logic [31:0]      data;
    logic [ROB_W-1:0] rob;
  } res_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cdb_writeback_queue_if #(.N_FU(N_FU), .DEPTH(DEPTH), .ROB_W(ROB_W), .PRN_W(PRN_W)) bus ();

  cdb_writeback_queue #(
    .N_FU(N_FU), .DEPTH(DEPTH), .ROB_W(ROB_W), .PRF(PRF), .PRN_W(PRN_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int   checks = 0;
  int   errors = 0;
  res_t mq[$];
  logic pv [N_FU];
  res_t pr [N_FU];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_pending();
    logic a = 1'b0;
    for (int i = 0; i < N_FU; i++) a |= pv[i];
    return a;
  endfunction

  function automatic res_t mk(input int prn, input logic [31:0] data, input int rob);
    res_t r;
    r.prn  = PRN_W'(prn);
    r.data = data;
    r.rob  = ROB_W'(rob);
    return r;
  endfunction

  task automatic apply_stimulus(input logic fl);
    bus.flush = fl;
    for (int i = 0; i < N_FU; i++) begin
      bus.fu_valid[i]   = pv[i];
      bus.fu_prn[i]     = pr[i].prn;
      bus.fu_data[i]    = pr[i].data;
      bus.fu_rob_idx[i] = pr[i].rob;
    end
  endtask

  // Expected outputs follow directly from the queue of pending results.
  task automatic check_output(input logic fl);
    int   n;
    logic en;
    res_t e;
    n = mq.size();
    check("fu_ready", bus.fu_ready, ((DEPTH - n) >= N_FU));
    check("count", bus.count, n);
    for (int k = 0; k < 2; k++) begin
      en = (n > k) && !fl;
      e  = en ? mq[k] : '0;
      check($sformatf("wr_en%0d", k), bus.wr_en[k], en);
      check($sformatf("wr_idx%0d", k), bus.wr_idx[k], e.prn);
      check($sformatf("wr_data%0d", k), bus.wr_data[k], e.data);
      check($sformatf("cdb_rob%0d", k), bus.cdb_rob_idx[k], e.rob);
    end
  endtask

  task automatic step(input logic fl);
    int   n;
    logic rdy;
    apply_stimulus(fl);
    #1;
    check_output(fl);
    n   = mq.size();
    rdy = (DEPTH - n) >= N_FU;
    @(posedge clock);
    if (fl) begin
      mq.delete();
      for (int i = 0; i < N_FU; i++) pv[i] = 1'b0;
    end else begin
      for (int k = 0; k < ((n >= 2) ? 2 : n); k++) void'(mq.pop_front());
      if (rdy) begin
        for (int i = 0; i < N_FU; i++) begin
          if (pv[i]) begin
            mq.push_back(pr[i]);
            pv[i] = 1'b0;
          end
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int b = 0;
    while ((mq.size() != 0 || any_pending()) && b < 60) begin
      step(1'b0);
      b++;
    end
    checks++;
    if (b >= 60) begin
      errors++;
      $error("[TB] FAIL drain_timeout observed=%0d expected=0", mq.size());
    end
  endtask

  task automatic load(input int first_prn, input int nports);
    for (int i = 0; i < nports; i++) begin
      pv[i] = 1'b1;
      pr[i] = mk(first_prn + i, 32'hA000_0000 + 32'(first_prn + i), (first_prn + i) % 32);
    end
  endtask

  initial begin
    int batches;
    int guard;
    logic fl;

    reset = 1'b0;
    for (int i = 0; i < N_FU; i++) begin
      pv[i] = 1'b0;
      pr[i] = '0;
    end
    apply_stimulus(1'b0);
    repeat (2) @(negedge clock);
    $display("[TB] reset state");
    check_output(1'b0);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] single result on FU2");
    pv[2] = 1'b1;
    pr[2] = mk(17, 32'hDEADBEEF, 3);
    step(1'b0);
    apply_stimulus(1'b0);
    #1;
    check("single_wr_en", bus.wr_en, 2'b01);
    check("single_idx", bus.wr_idx[0], 17);
    check("single_data", bus.wr_data[0], 32'hDEADBEEF);
    check("single_rob", bus.cdb_rob_idx[0], 3);
    step(1'b0);
    check("single_count_after", bus.count, 0);

    $display("[TB] four-wide burst");
    load(10, 4);
    step(1'b0);
    apply_stimulus(1'b0);
    #1;
    check("burst_en_a", bus.wr_en, 2'b11);
    check("burst_idx_a0", bus.wr_idx[0], 10);
    check("burst_idx_a1", bus.wr_idx[1], 11);
    step(1'b0);
    check("burst_idx_b0", bus.wr_idx[0], 12);
    check("burst_idx_b1", bus.wr_idx[1], 13);
    step(1'b0);
    drain();

    $display("[TB] back-pressure");
    batches = 0;
    guard   = 0;
    while (batches < 3 && guard < 40) begin
      if (!any_pending()) begin
        load(20 + batches * 4, 4);
        batches++;
      end
      step(1'b0);
      guard++;
    end
    drain();

    $display("[TB] reset mid-burst");
    load(40, 4);
    step(1'b0);
    load(44, 3);
    step(1'b0);
    apply_stimulus(1'b0);
    #1;
    check("ready_at_5", bus.fu_ready, 0);
    check("count_at_5", bus.count, 5);
    #1;
    reset = 1'b0;
    mq.delete();
    #1;
    check_output(1'b0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0);

    $display("[TB] flush with count 6");
    load(50, 4);
    step(1'b0);
    load(54, 4);
    step(1'b0);
    load(60, 3);
    apply_stimulus(1'b1);
    #1;
    check("count_before_flush", bus.count, 6);
    check("flush_wr_en", bus.wr_en, 2'b00);
    step(1'b1);
    apply_stimulus(1'b0);
    #1;
    check("count_after_flush", bus.count, 0);
    repeat (3) step(1'b0);

    $display("[TB] wrap-around");
    load(70, 4);
    step(1'b0);
    drain();
    load(74, 2);
    step(1'b0);
    drain();
    load(80, 4);
    step(1'b0);
    drain();

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_FU; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 45) begin
          pv[i] = 1'b1;
          pr[i] = mk($urandom_range(0, PRF - 1), $urandom, $urandom_range(0, 31));
        end
      end
      fl = ($urandom_range(0, 99) < 3);
      step(fl);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
